pc_next_unit: RTL and testbench
===============================

PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 stall  input  1  fetch/decode stall; PC and state hold.
REQ-005 branch_taken  input  1  decode-stage conditional branch resolved taken.
REQ-006 branch_base  input  32  PC+4 of the instruction in decode.
REQ-007 branch_offset_sl2  input  32  sign-extended offset already shifted left by 2 (word offset ×4).
REQ-008 jump  input  1  decode-stage J/JAL.
REQ-009 jump_index  input  26  instr[25:0] of the jump.
REQ-010 jr  input  1  decode-stage JR/JALR.
REQ-011 jr_target  input  32  register-sourced target.
REQ-012 pc  output  32  current fetch address, registered.
REQ-013 pc_plus4  output  32  pc + 4, combinational, mod 2^32.
REQ-014 flush  output  1  kill the instruction fetched this cycle (IF/ID bubble).
REQ-015 misalign  output  1  one-cycle pulse: jr_target[1:0] != 0 was accepted.
REQ-016 redirect_err  output  1  one-cycle pulse: redirect request ignored in post-redirect state.

Function
REQ-017 States: S_RUN, S_POST; S_POST is one cycle following an accepted redirect.
REQ-018 Redirect request = jr | jump | branch_taken; priority jr > jump > branch_taken.
REQ-019 Targets: jr -> {jr_target[31:2],2'b00}; jump -> {branch_base[31:28],jump_index,2'b00}; branch -> branch_base + branch_offset_sl2, 32-bit wrap, carry discarded.
REQ-020 stall=1: pc, state unchanged; flush=0; misalign=0; redirect_err=0; requests ignored (not queued).
REQ-021 S_RUN, stall=0, no request: pc <= pc_plus4 (0xFFFF_FFFC wraps to 0x0000_0000).
REQ-022 S_RUN, stall=0, request: pc <= selected target next edge; state <= S_POST.
REQ-023 S_POST, stall=0: pc <= pc_plus4; state <= S_RUN; any request ignored and redirect_err=1 that cycle.
REQ-024 S_POST, stall=1: state held in S_POST.
REQ-025 misalign pulses in the accept cycle only when jr wins priority and jr_target[1:0]!=0; target still forced aligned.
REQ-026 flush, misalign, redirect_err combinational from state and inputs; zero outside stated conditions.

Reset
REQ-027 rst_n=0 asynchronously: pc=RESET_PC, state=S_RUN; all pulse outputs 0 while rst_n=0.
REQ-028 Reset mid-S_POST or mid-stall discards pending state; first edge after release fetches RESET_PC+4 (no request).

Configuration
REQ-029 Macro BRANCH_DELAY_SLOT_EN defined: flush held 0 always; the instruction in IF on redirect (delay slot) executes; S_POST still entered, requests there ignored with redirect_err=1.
REQ-030 Macro undefined: flush=1 exactly in S_RUN cycles with stall=0 and a redirect request; otherwise 0.

Verification
REQ-031 Reset, RESET_PC=0, 3 edges no requests -> pc 0x0,0x4,0x8,0xC; flush=0.
REQ-032 pc=0x100, branch_taken, branch_base=0x104, offset_sl2=0xFFFF_FFF0 -> flush=1 (macro off); next pc=0xF4; following cycle S_POST, pc=0xF8.
REQ-033 jr=1,jump=1,branch_taken=1, jr_target=0x0000_2003 -> pc=0x2000, misalign pulse 1 cycle, jump ignored.
REQ-034 jump, branch_base=0x3000_0010, jump_index=0x000_0040 with stall=1 for 2 cycles then 0 -> pc held 2 cycles, then 0x3000_0100.
REQ-035 Redirect accepted, then branch_taken in S_POST -> redirect_err=1, pc=target+4; macro on: flush stays 0 throughout.
REQ-036 pc=0xFFFF_FFFC no request -> pc=0x0; rst_n low in S_POST -> pc=RESET_PC immediately, state S_RUN.

Source files
------------

// File: rtl/pc_next_unit.sv
// Next-PC selection for the fetch stage: sequential fetch, JR/J/branch redirects, one post-redirect cycle.
// Optional BRANCH_DELAY_SLOT_EN: the fetch slot after a redirect executes instead of being flushed.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_base,
    input  logic [31:0] branch_offset_sl2,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        misalign,
    output logic        redirect_err
);

    localparam int unsigned PC_W = 32;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_POST = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [PC_W-1:0]   target;
    logic              redirect_req;

    assign pc_plus4     = pc + PC_W'(4);
    assign redirect_req = jr | jump | branch_taken;

    // Redirect target by priority jr > jump > branch.
    always_comb begin
        target = branch_base + branch_offset_sl2;
        if (jr) begin
            target = {jr_target[31:2], 2'b00};
        end else if (jump) begin
            target = {branch_base[31:28], jump_index, 2'b00};
        end
    end

    // Next state, next pc and the per-cycle pulse outputs.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        flush        = 1'b0;
        misalign     = 1'b0;
        redirect_err = 1'b0;
        if (rst_n && !stall) begin
            case (state)
                S_RUN: begin
                    if (redirect_req) begin
                        pc_nxt    = target;
                        state_nxt = S_POST;
                        misalign  = jr & (jr_target[1:0] != 2'b00);
`ifndef BRANCH_DELAY_SLOT_EN
                        flush     = 1'b1;
`endif
                    end else begin
                        pc_nxt = pc_plus4;
                    end
                end
                S_POST: begin
                    pc_nxt       = pc_plus4;
                    state_nxt    = S_RUN;
                    redirect_err = redirect_req;
                end
                default: begin
                    state_nxt = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            state <= S_RUN;
        end else begin
            pc    <= pc_nxt;
            state <= state_nxt;
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_next_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_base = '0;
    logic [31:0] branch_offset_sl2 = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jr = 1'b0;
    logic [31:0] jr_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        misalign;
    logic        redirect_err;

    int compared = 0;
    int mismatched = 0;
    bit cmp_en = 1'b0;

    pc_next_unit #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .branch_taken      (branch_taken),
        .branch_base       (branch_base),
        .branch_offset_sl2 (branch_offset_sl2),
        .jump              (jump),
        .jump_index        (jump_index),
        .jr                (jr),
        .jr_target         (jr_target),
        .pc                (pc),
        .pc_plus4          (pc_plus4),
        .flush             (flush),
        .misalign          (misalign),
        .redirect_err      (redirect_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the fetch address and whether the last accepted cycle was a redirect.
    logic [31:0] pc_m = RESET_PC;
    bit          post_m = 1'b0;

    function automatic logic [31:0] model_target();
        if (jr) return jr_target & 32'hFFFF_FFFC;
        if (jump) return (branch_base & 32'hF000_0000) | ({6'd0, jump_index} * 32'd4);
        return branch_base + branch_offset_sl2;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_m   <= RESET_PC;
            post_m <= 1'b0;
        end else if (!stall) begin
            if (post_m) begin
                pc_m   <= pc_m + 32'd4;
                post_m <= 1'b0;
            end else if (jr || jump || branch_taken) begin
                pc_m   <= model_target();
                post_m <= 1'b1;
            end else begin
                pc_m <= pc_m + 32'd4;
            end
        end
    end

    // Every-cycle comparison, midway between rising edges.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit req;
            bit live;
            req  = jr || jump || branch_taken;
            live = rst_n && !stall;
            chk("pc", pc, pc_m);
            chk("pc_plus4", pc_plus4, pc_m + 32'd4);
            chk("flush", 32'(flush), 32'(live && !post_m && req && !DS));
            chk("misalign", 32'(misalign), 32'(live && !post_m && jr && (jr_target % 4 != 0)));
            chk("redirect_err", 32'(redirect_err), 32'(live && post_m && req));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clr();
        stall = 0; branch_taken = 0; jump = 0; jr = 0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("lit_reset_pc", pc, RESET_PC);
        cmp_en = 1'b1;
        cyc(); cyc();
        rst_n = 1'b1;
        // Sequential fetch from reset.
        cyc(); chk("lit_seq0", pc, 32'h4);
        cyc(); chk("lit_seq1", pc, 32'h8);
        cyc(); chk("lit_seq2", pc, 32'hC); chk("lit_seq_flush", 32'(flush), 32'h0);
        // Reach pc=0x100 in run state, then a backward branch.
        jr = 1; jr_target = 32'h0000_00FC;
        cyc(); clr(); chk("lit_jr_fc", pc, 32'hFC);
        cyc(); chk("lit_pc_100", pc, 32'h100);
        branch_taken = 1; branch_base = 32'h104; branch_offset_sl2 = 32'hFFFF_FFF0;
        #1 chk("lit_br_flush", 32'(flush), 32'(!DS));
        cyc(); clr(); chk("lit_br_target", pc, 32'hF4);
        cyc(); chk("lit_br_post", pc, 32'hF8);
        // All three requests, misaligned jr wins.
        jr = 1; jump = 1; branch_taken = 1; jr_target = 32'h0000_2003;
        #1 chk("lit_misalign", 32'(misalign), 32'h1);
        cyc(); clr(); chk("lit_jr_align", pc, 32'h2000);
        chk("lit_misalign_end", 32'(misalign), 32'h0);
        cyc();
        // Jump held off by a two-cycle stall.
        jump = 1; branch_base = 32'h3000_0010; jump_index = 26'h000_0040; stall = 1;
        cyc(); chk("lit_stall0", pc, 32'h2004);
        cyc(); chk("lit_stall1", pc, 32'h2004);
        stall = 0;
        cyc(); clr(); chk("lit_jump", pc, 32'h3000_0100);
        cyc();
        // Request in post-redirect cycle is ignored.
        branch_taken = 1; branch_base = 32'h1000; branch_offset_sl2 = 32'h20;
        cyc(); chk("lit_br2", pc, 32'h1020);
        #1 chk("lit_redirect_err", 32'(redirect_err), 32'h1);
        chk("lit_post_flush", 32'(flush), 32'h0);
        cyc(); clr(); chk("lit_post_seq", pc, 32'h1024);
        // Wrap at top of address space, then reset during post state.
        jr = 1; jr_target = 32'hFFFF_FFF8;
        cyc(); clr();
        cyc(); chk("lit_top", pc, 32'hFFFF_FFFC);
        cyc(); chk("lit_wrap", pc, 32'h0);
        jr = 1; jr_target = 32'h500;
        cyc(); clr(); chk("lit_jr_500", pc, 32'h500);
        rst_n = 1'b0;
        #1 chk("lit_async_rst", pc, RESET_PC);
        cyc();
        rst_n = 1'b1;
        cyc(); chk("lit_rst_release", pc, RESET_PC + 32'd4);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            stall        = ($urandom_range(0, 4) == 0);
            jr           = ($urandom_range(0, 5) == 0);
            jump         = ($urandom_range(0, 4) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            jr_target    = $urandom;
            branch_base  = $urandom;
            branch_offset_sl2 = $urandom;
            jump_index   = 26'($urandom);
            if (!rst_n) rst_n = 1'b1;
            else rst_n = ($urandom_range(0, 149) != 0);
            cyc();
        end
        clr();
        rst_n = 1'b1;
        cyc();
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
